// File: rtl/fb_swap_pkg.sv
// Shared types and helpers for the framebuffer double-buffer sequencer.
package fb_swap_pkg;

  typedef enum logic [1:0] {
    RENDERING,
    WAIT_VBLANK,
    SWAP
  } swap_state_t;

  localparam logic [7:0] OVERRUN_MAX = 8'hFF;

  function automatic int unsigned fb_addr_width(input int unsigned hor, input int unsigned ver);
    return $clog2(hor * ver);
  endfunction

endpackage

// File: rtl/vblank_divider.sv
// Frame-rate divider: flags every FRAME_DIV-th vsync_start as a swap point.
module vblank_divider #(
  parameter int unsigned FRAME_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync_start,
  output logic vblank_hit
);

  localparam int unsigned CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q;
    if (vsync_start) div_d = (div_q == LAST) ? '0 : div_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_q <= '0;
    else      div_q <= div_d;
  end

  assign vblank_hit = vsync_start && (div_q == '0);

endmodule

// File: rtl/fb_swap_controller.sv
// Double-buffer sequencer: routes renderer writes to the back buffer, scan-out
// reads to the front buffer, and swaps only at divided vertical-blank points.
module fb_swap_controller
  import fb_swap_pkg::*;
#(
  parameter int unsigned HOR_ACTIVE_PIXELS = 640,
  parameter int unsigned VER_ACTIVE_PIXELS = 480,
  parameter int unsigned FRAME_DIV         = 1,
  parameter int unsigned RD_LATENCY        = 1,
  localparam int unsigned ADDR_WIDTH = fb_addr_width(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vsync_start,
  input  logic                  render_done,
  output logic                  swap,
  input  logic                  render_wr_en,
  input  logic [ADDR_WIDTH-1:0] render_wr_addr,
  input  logic                  render_wr_data,
  output logic                  fb0_wr_en,
  output logic                  fb1_wr_en,
  output logic [ADDR_WIDTH-1:0] fb0_wr_addr,
  output logic [ADDR_WIDTH-1:0] fb1_wr_addr,
  output logic                  fb0_wr_data,
  output logic                  fb1_wr_data,
  input  logic [ADDR_WIDTH-1:0] disp_rd_addr,
  output logic [ADDR_WIDTH-1:0] fb0_rd_addr,
  output logic [ADDR_WIDTH-1:0] fb1_rd_addr,
  input  logic                  fb0_rd_data,
  input  logic                  fb1_rd_data,
  output logic                  disp_rd_data,
  output logic                  front,
  output logic [7:0]            overrun_count
);

  swap_state_t state_q, state_d;
  logic        front_q, front_d;
  logic        swap_q, swap_d;
  logic [7:0]  overrun_q, overrun_d;
  logic        vblank_hit;

  logic                  fb0_wr_en_q, fb0_wr_en_d, fb1_wr_en_q, fb1_wr_en_d;
  logic [ADDR_WIDTH-1:0] fb0_wr_addr_q, fb0_wr_addr_d, fb1_wr_addr_q, fb1_wr_addr_d;
  logic                  fb0_wr_data_q, fb0_wr_data_d, fb1_wr_data_q, fb1_wr_data_d;
  logic [RD_LATENCY-1:0] front_dly_q, front_dly_d;

  vblank_divider #(.FRAME_DIV(FRAME_DIV)) u_vblank_divider (
    .clk        (clk),
    .rst        (rst),
    .vsync_start(vsync_start),
    .vblank_hit (vblank_hit)
  );

  always_comb begin
    state_d   = state_q;
    front_d   = front_q;
    swap_d    = swap_q;
    overrun_d = overrun_q;
    case (state_q)
      RENDERING: begin
        if (render_done && vblank_hit) begin
          state_d = SWAP;
          front_d = ~front_q;
          swap_d  = 1'b1;
        end else if (render_done) begin
          state_d = WAIT_VBLANK;
        end else if (vblank_hit && overrun_q != OVERRUN_MAX) begin
          overrun_d = overrun_q + 8'd1;
        end
      end
      WAIT_VBLANK: begin
        if (vblank_hit) begin
          state_d = SWAP;
          front_d = ~front_q;
          swap_d  = 1'b1;
        end
      end
      SWAP: begin
        // Renderer acknowledges by leaving DONE; only then release the request.
        if (!render_done) begin
          state_d = RENDERING;
          swap_d  = 1'b0;
        end
      end
      default: state_d = RENDERING;
    endcase
  end

  always_comb begin
    fb0_wr_en_d   = render_wr_en & front_q;
    fb1_wr_en_d   = render_wr_en & ~front_q;
    fb0_wr_addr_d = fb0_wr_en_d ? render_wr_addr : fb0_wr_addr_q;
    fb1_wr_addr_d = fb1_wr_en_d ? render_wr_addr : fb1_wr_addr_q;
    fb0_wr_data_d = fb0_wr_en_d ? render_wr_data : fb0_wr_data_q;
    fb1_wr_data_d = fb1_wr_en_d ? render_wr_data : fb1_wr_data_q;
  end

  // Front index is delayed to match RAM latency so in-flight reads stay consistent.
  always_comb begin
    front_dly_d    = front_dly_q;
    front_dly_d[0] = front_q;
    for (int unsigned i = 1; i < RD_LATENCY; i++) front_dly_d[i] = front_dly_q[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RENDERING;
      front_q       <= 1'b0;
      swap_q        <= 1'b0;
      overrun_q     <= '0;
      fb0_wr_en_q   <= 1'b0;
      fb1_wr_en_q   <= 1'b0;
      fb0_wr_addr_q <= '0;
      fb1_wr_addr_q <= '0;
      fb0_wr_data_q <= 1'b0;
      fb1_wr_data_q <= 1'b0;
      front_dly_q   <= '0;
    end else begin
      state_q       <= state_d;
      front_q       <= front_d;
      swap_q        <= swap_d;
      overrun_q     <= overrun_d;
      fb0_wr_en_q   <= fb0_wr_en_d;
      fb1_wr_en_q   <= fb1_wr_en_d;
      fb0_wr_addr_q <= fb0_wr_addr_d;
      fb1_wr_addr_q <= fb1_wr_addr_d;
      fb0_wr_data_q <= fb0_wr_data_d;
      fb1_wr_data_q <= fb1_wr_data_d;
      front_dly_q   <= front_dly_d;
    end
  end

  assign swap          = swap_q;
  assign front         = front_q;
  assign overrun_count = overrun_q;
  assign fb0_wr_en     = fb0_wr_en_q;
  assign fb1_wr_en     = fb1_wr_en_q;
  assign fb0_wr_addr   = fb0_wr_addr_q;
  assign fb1_wr_addr   = fb1_wr_addr_q;
  assign fb0_wr_data   = fb0_wr_data_q;
  assign fb1_wr_data   = fb1_wr_data_q;
  assign fb0_rd_addr   = disp_rd_addr;
  assign fb1_rd_addr   = disp_rd_addr;
  assign disp_rd_data  = front_dly_q[RD_LATENCY-1] ? fb1_rd_data : fb0_rd_data;

endmodule

// File: tb/tb_fb_swap_controller.sv
// Bench for fb_swap_controller: default instance (A) and a FRAME_DIV=3 /
// RD_LATENCY=2 instance (B), checked cycle-by-cycle against a reference model.
module tb_fb_swap_controller;

  localparam int unsigned AW = 19;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_vs, a_rd, a_wr_en, a_wr_data, a_fb0_rd, a_fb1_rd;
  logic [AW-1:0] a_wr_addr, a_disp_addr;
  logic          a_swap, a_fb0_we, a_fb1_we, a_fb0_wd, a_fb1_wd, a_disp, a_front;
  logic [AW-1:0] a_fb0_wa, a_fb1_wa, a_fb0_ra, a_fb1_ra;
  logic [7:0]    a_ovr;

  logic          b_vs, b_rd, b_wr_en, b_wr_data, b_fb0_rd, b_fb1_rd;
  logic [AW-1:0] b_wr_addr, b_disp_addr;
  logic          b_swap, b_fb0_we, b_fb1_we, b_fb0_wd, b_fb1_wd, b_disp, b_front;
  logic [AW-1:0] b_fb0_wa, b_fb1_wa, b_fb0_ra, b_fb1_ra;
  logic [7:0]    b_ovr;

  fb_swap_controller #(
    .HOR_ACTIVE_PIXELS(640), .VER_ACTIVE_PIXELS(480), .FRAME_DIV(1), .RD_LATENCY(1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .vsync_start(a_vs), .render_done(a_rd), .swap(a_swap),
    .render_wr_en(a_wr_en), .render_wr_addr(a_wr_addr), .render_wr_data(a_wr_data),
    .fb0_wr_en(a_fb0_we), .fb1_wr_en(a_fb1_we), .fb0_wr_addr(a_fb0_wa), .fb1_wr_addr(a_fb1_wa),
    .fb0_wr_data(a_fb0_wd), .fb1_wr_data(a_fb1_wd), .disp_rd_addr(a_disp_addr),
    .fb0_rd_addr(a_fb0_ra), .fb1_rd_addr(a_fb1_ra), .fb0_rd_data(a_fb0_rd), .fb1_rd_data(a_fb1_rd),
    .disp_rd_data(a_disp), .front(a_front), .overrun_count(a_ovr)
  );

  fb_swap_controller #(
    .HOR_ACTIVE_PIXELS(640), .VER_ACTIVE_PIXELS(480), .FRAME_DIV(3), .RD_LATENCY(2)
  ) u_dut_b (
    .clk(clk), .rst(rst), .vsync_start(b_vs), .render_done(b_rd), .swap(b_swap),
    .render_wr_en(b_wr_en), .render_wr_addr(b_wr_addr), .render_wr_data(b_wr_data),
    .fb0_wr_en(b_fb0_we), .fb1_wr_en(b_fb1_we), .fb0_wr_addr(b_fb0_wa), .fb1_wr_addr(b_fb1_wa),
    .fb0_wr_data(b_fb0_wd), .fb1_wr_data(b_fb1_wd), .disp_rd_addr(b_disp_addr),
    .fb0_rd_addr(b_fb0_ra), .fb1_rd_addr(b_fb1_ra), .fb0_rd_data(b_fb0_rd), .fb1_rd_data(b_fb1_rd),
    .disp_rd_data(b_disp), .front(b_front), .overrun_count(b_ovr)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:  return 32'(a_swap);
      1:  return 32'(a_front);
      2:  return 32'(a_ovr);
      3:  return 32'(a_fb0_we);
      4:  return 32'(a_fb1_we);
      5:  return 32'(a_fb0_wa);
      6:  return 32'(a_fb1_wa);
      7:  return 32'(a_fb0_wd);
      8:  return 32'(a_fb1_wd);
      9:  return 32'(b_swap);
      10: return 32'(b_front);
      11: return 32'(b_ovr);
      12: return 32'(b_disp);
      13: return 32'(a_fb0_ra);
      default: return 32'hDEAD;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Reference model state: 0=RENDERING 1=WAIT_VBLANK 2=SWAP
  int m_a_st, m_a_fr, m_a_sw, m_a_ov, m_a_dv;
  int m_b_st, m_b_fr, m_b_sw, m_b_ov, m_b_dv, m_b_h2;

  task automatic model_reset();
    m_a_st = 0; m_a_fr = 0; m_a_sw = 0; m_a_ov = 0; m_a_dv = 0;
    m_b_st = 0; m_b_fr = 0; m_b_sw = 0; m_b_ov = 0; m_b_dv = 0; m_b_h2 = 0;
  endtask

  task automatic fsm_step(input int fd, input logic vs, input logic rd,
                          inout int st, inout int fr, inout int sw, inout int ov, inout int dv);
    bit hit;
    hit = vs && (dv == 0);
    if (st == 0) begin
      if (rd && hit) begin st = 2; fr = 1 - fr; sw = 1; end
      else if (rd) st = 1;
      else if (hit && ov < 255) ov = ov + 1;
    end else if (st == 1) begin
      if (hit) begin st = 2; fr = 1 - fr; sw = 1; end
    end else begin
      if (!rd) begin st = 0; sw = 0; end
    end
    if (vs) dv = (dv + 1) % fd;
  endtask

  task automatic tick();
    if (rst) begin
      int a_fr_pre, b_fr_pre;
      a_fr_pre = m_a_fr;
      b_fr_pre = m_b_fr;
      fsm_step(1, a_vs, a_rd, m_a_st, m_a_fr, m_a_sw, m_a_ov, m_a_dv);
      fsm_step(3, b_vs, b_rd, m_b_st, m_b_fr, m_b_sw, m_b_ov, m_b_dv);
      push("a_swap", 0, 32'(m_a_sw));
      push("a_front", 1, 32'(m_a_fr));
      push("a_ovr", 2, 32'(m_a_ov));
      push("a_fb0_we", 3, 32'(a_wr_en && a_fr_pre == 1));
      push("a_fb1_we", 4, 32'(a_wr_en && a_fr_pre == 0));
      if (a_wr_en && a_fr_pre == 1) begin
        push("a_fb0_wa", 5, 32'(a_wr_addr));
        push("a_fb0_wd", 7, 32'(a_wr_data));
      end
      if (a_wr_en && a_fr_pre == 0) begin
        push("a_fb1_wa", 6, 32'(a_wr_addr));
        push("a_fb1_wd", 8, 32'(a_wr_data));
      end
      push("a_rd_addr", 13, 32'(a_disp_addr));
      push("b_swap", 9, 32'(m_b_sw));
      push("b_front", 10, 32'(m_b_fr));
      push("b_ovr", 11, 32'(m_b_ov));
      push("b_disp", 12, 32'((m_b_h2 != 0) ? b_fb1_rd : b_fb0_rd));
      m_b_h2 = b_fr_pre;
    end
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    a_vs = 0; a_rd = 0; a_wr_en = 0; a_wr_addr = '0; a_wr_data = 0;
    b_vs = 0; b_rd = 0;
    ticks(2);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    a_vs = 0; a_rd = 0; a_wr_en = 0; a_wr_addr = '0; a_wr_data = 0;
    a_disp_addr = 19'h00ABC; a_fb0_rd = 0; a_fb1_rd = 1;
    b_vs = 0; b_rd = 0; b_wr_en = 0; b_wr_addr = '0; b_wr_data = 0;
    b_disp_addr = '0; b_fb0_rd = 0; b_fb1_rd = 1;
    model_reset();
    #12;
    check_eq("rst_swap", 32'(a_swap), 0);
    check_eq("rst_front", 32'(a_front), 0);
    check_eq("rst_ovr", 32'(a_ovr), 0);
    check_eq("rst_fb1_we", 32'(a_fb1_we), 0);
    check_eq("rst_fb1_wa", 32'(a_fb1_wa), 0);

    // Overruns while the renderer never finishes
    do_reset();
    for (int k = 0; k < 3; k++) begin
      a_vs = 1; tick(); a_vs = 0; ticks(3);
      check_eq("ovr_swap_low", 32'(a_swap), 0);
    end
    check_eq("ovr_three", 32'(a_ovr), 3);
    check_eq("ovr_front", 32'(a_front), 0);

    // Swap handshake timing
    do_reset();
    ticks(10);
    a_rd = 1; ticks(40);
    check_eq("wait_no_swap", 32'(a_swap), 0);
    a_vs = 1; tick(); a_vs = 0;
    check_eq("swap_front", 32'(a_front), 1);
    check_eq("swap_high", 32'(a_swap), 1);
    ticks(3);
    check_eq("swap_hold", 32'(a_swap), 1);
    a_rd = 0; tick();
    check_eq("swap_release", 32'(a_swap), 0);
    check_eq("swap_no_ovr", 32'(a_ovr), 0);

    // Write routing to the back buffer, before and after a swap
    do_reset();
    a_wr_en = 1; a_wr_addr = 19'h00123; a_wr_data = 1; tick(); a_wr_en = 0;
    check_eq("wr_fb1_en", 32'(a_fb1_we), 1);
    check_eq("wr_fb1_addr", 32'(a_fb1_wa), 32'h123);
    check_eq("wr_fb1_data", 32'(a_fb1_wd), 1);
    check_eq("wr_fb0_off", 32'(a_fb0_we), 0);
    a_rd = 1; a_vs = 1; tick(); a_vs = 0; a_rd = 0; tick();
    a_wr_en = 1; a_wr_addr = 19'h002AB; a_wr_data = 1; tick();
    check_eq("wr_fb0_en", 32'(a_fb0_we), 1);
    check_eq("wr_fb0_addr", 32'(a_fb0_wa), 32'h2AB);
    check_eq("wr_fb1_off", 32'(a_fb1_we), 0);
    a_wr_addr = 19'h7FFFF; a_wr_data = 0; tick(); a_wr_en = 0; tick();

    // FRAME_DIV=3: only the 1st, 4th and 7th vsync are swap points
    do_reset();
    b_rd = 1; tick();
    for (int k = 0; k < 9; k++) begin
      b_vs = 1; tick(); b_vs = 0;
      check_eq($sformatf("div_swap_%0d", k), 32'(b_swap), 32'((k % 3) == 0));
      if ((k % 3) == 0) begin b_rd = 0; tick(); b_rd = 1; tick(); end
      else ticks(2);
    end
    check_eq("div_no_ovr", 32'(b_ovr), 0);

    // render_done rising together with vsync is a swap point
    do_reset();
    a_rd = 1; a_vs = 1; tick(); a_vs = 0;
    check_eq("same_cyc_swap", 32'(a_swap), 1);
    check_eq("same_cyc_ovr", 32'(a_ovr), 0);
    a_rd = 0; tick();

    // Saturating overrun counter
    do_reset();
    for (int k = 0; k < 300; k++) begin a_vs = 1; tick(); a_vs = 0; tick(); end
    check_eq("ovr_saturate", 32'(a_ovr), 255);

    // RD_LATENCY=2 read mux follows front two cycles late
    do_reset();
    b_fb0_rd = 0; b_fb1_rd = 1;
    b_rd = 1; b_vs = 1; tick(); b_vs = 0;
    check_eq("lat_front", 32'(b_front), 1);
    check_eq("lat_disp_0", 32'(b_disp), 0);
    tick();
    check_eq("lat_disp_1", 32'(b_disp), 0);
    tick();
    check_eq("lat_disp_2", 32'(b_disp), 1);

    // Asynchronous reset in the middle of SWAP
    a_rd = 1; a_vs = 1; tick(); a_vs = 0;
    check_eq("pre_rst_swap", 32'(a_swap), 1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_swap_a", 32'(a_swap), 0);
    check_eq("async_front_a", 32'(a_front), 0);
    check_eq("async_swap_b", 32'(b_swap), 0);
    check_eq("async_front_b", 32'(b_front), 0);
    do_reset();
    ticks(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
